// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Purpose  : Multi-channel switch debouncer. Each of NUM_CH raw inputs passes
//            through a 2-flop synchroniser and a stability counter; the
//            filtered level only changes after the synchronised input has
//            differed from it for DEBOUNCE_LIMIT consecutive clock edges.
//            One-cycle press (rise) and release (fall) strobes accompany
//            each level change.
// Optional : Define DEBOUNCE_REPEAT_EN to build per-channel auto-repeat
//            timers driving o_Repeat; otherwise o_Repeat is tied to 0.
// Ports    : i_Clk     - system clock
//            i_Rst_L   - synchronous reset, active-low
//            i_Switch  - raw asynchronous switch inputs, bit n = channel n
//            o_Switch  - debounced level per channel
//            o_Rise    - one-cycle strobe when o_Switch[n] goes 0->1
//            o_Fall    - one-cycle strobe when o_Switch[n] goes 1->0
//            o_Repeat  - auto-repeat strobe while a channel is held high
// Revision : 1.0 - initial release
// ============================================================================
module debounce_multi #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned CNT_W          = 18,
  parameter int unsigned REPEAT_DELAY   = 12500000,
  parameter int unsigned REPEAT_PERIOD  = 2500000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Repeat
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("debounce_multi: NUM_CH must be >= 1");
  end
  if (DEBOUNCE_LIMIT < 1) begin : g_bad_limit
    $error("debounce_multi: DEBOUNCE_LIMIT must be >= 1");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_LIMIT)) begin : g_bad_cnt_w
    $error("debounce_multi: CNT_W too small for DEBOUNCE_LIMIT");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("debounce_multi: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

`ifdef DEBOUNCE_REPEAT_EN
  // The timer only ever holds values up to max(delay, period) - 1.
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                   : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
`endif

  // --------------------------------------------------------------------------
  // Per-channel datapath; channels share no state.
  // --------------------------------------------------------------------------
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic             sync1;
    logic             sync2;
    logic             state;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // The level flips on the edge where the disagreement count has already
    // reached DEBOUNCE_LIMIT-1, i.e. the DEBOUNCE_LIMIT-th disagreeing sample.
    assign flip = (sync2 != state) && (cnt == CNT_W'(DEBOUNCE_LIMIT - 1));

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        state <= 1'b0;
        cnt   <= '0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        sync1 <= i_Switch[n];
        sync2 <= sync1;
        rise  <= 1'b0;
        fall  <= 1'b0;
        if (sync2 == state) begin
          // Any agreeing sample restarts the stability count.
          cnt <= '0;
        end else if (flip) begin
          state <= sync2;
          cnt   <= '0;
          rise  <= sync2;
          fall  <= ~sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign o_Switch[n] = state;
    assign o_Rise[n]   = rise;
    assign o_Fall[n]   = fall;

`ifdef DEBOUNCE_REPEAT_EN
    logic [RPT_W-1:0] rpt;
    logic             rpt_phase;  // 0: waiting for first repeat, 1: periodic
    logic             rep;

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        rpt       <= '0;
        rpt_phase <= 1'b0;
        rep       <= 1'b0;
      end else begin
        rep <= 1'b0;
        // A flip while low is the rise edge (timer starts from zero); a flip
        // while high is the fall edge, which must suppress any repeat.
        if (!state || flip) begin
          rpt       <= '0;
          rpt_phase <= 1'b0;
        end else if (!rpt_phase && rpt == RPT_W'(REPEAT_DELAY - 1)) begin
          rep       <= 1'b1;
          rpt       <= '0;
          rpt_phase <= 1'b1;
        end else if (rpt_phase && rpt == RPT_W'(REPEAT_PERIOD - 1)) begin
          rep <= 1'b1;
          rpt <= '0;
        end else begin
          rpt <= rpt + RPT_W'(1);
        end
      end
    end

    assign o_Repeat[n] = rep;
`else
    assign o_Repeat[n] = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_multi
// Purpose  : Self-checking bench for debounce_multi (2 channels, limit 8).
//            Expected rise/fall strobes are queued with their due cycle when
//            the stimulus is applied; a negedge monitor pops them and checks
//            level, strobes and repeat output every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned LIMIT  = 8;
  localparam int unsigned DELAY  = 20;
  localparam int unsigned PERIOD = 5;
  localparam int          LAT    = LIMIT + 2;  // drive edge -> o_Switch change
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] sw = 2'b11;
  logic [NUM_CH-1:0] level_out;
  logic [NUM_CH-1:0] rise_out;
  logic [NUM_CH-1:0] fall_out;
  logic [NUM_CH-1:0] rep_out;

  debounce_multi #(
    .NUM_CH         (NUM_CH),
    .DEBOUNCE_LIMIT (LIMIT),
    .CNT_W          (4),
    .REPEAT_DELAY   (DELAY),
    .REPEAT_PERIOD  (PERIOD)
  ) dut (
    .i_Clk    (clk),
    .i_Rst_L  (rst_n),
    .i_Switch (sw),
    .o_Switch (level_out),
    .o_Rise   (rise_out),
    .o_Fall   (fall_out),
    .o_Repeat (rep_out)
  );

  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    else
      passed++;
  endtask

  typedef struct {
    int          at;
    logic [1:0]  rise;
    logic [1:0]  fall;
  } ev_t;

  ev_t sb[$];

  // Insert in due-cycle order, merging events due on the same cycle.
  task automatic push_ev(input int at, input logic [1:0] r, input logic [1:0] f);
    ev_t e;
    int  pos;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at == at) begin
        e      = sb[i];
        e.rise = e.rise | r;
        e.fall = e.fall | f;
        sb[i]  = e;
        return;
      end
      if (sb[i].at > at && pos == sb.size()) pos = i;
    end
    e.at   = at;
    e.rise = r;
    e.fall = f;
    sb.insert(pos, e);
  endtask

  // ---------------------------------------------------------------- monitor
  logic [1:0] lvl = 2'b00;
  int         rise_at [2] = '{0, 0};

  always @(negedge clk) begin
    logic [1:0] exp_r;
    logic [1:0] exp_f;
    logic [1:0] exp_rep;
    ev_t        e;
    int         since;
    if (!rst_n) begin
      lvl = 2'b00;
    end else begin
      exp_r   = 2'b00;
      exp_f   = 2'b00;
      exp_rep = 2'b00;
      while (sb.size() > 0 && sb[0].at < cyc) begin
        check("missed_event", cyc, sb[0].at);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].at == cyc) begin
        e     = sb.pop_front();
        exp_r = e.rise;
        exp_f = e.fall;
      end
      lvl = (lvl | exp_r) & ~exp_f;
      for (int ch = 0; ch < 2; ch++) begin
        if (exp_r[ch]) rise_at[ch] = cyc;
        since = cyc - rise_at[ch];
        if (REP_EN && lvl[ch] && since >= DELAY && ((since - DELAY) % PERIOD) == 0)
          exp_rep[ch] = 1'b1;
      end
      check("level",  level_out, lvl);
      check("rise",   rise_out,  exp_r);
      check("fall",   fall_out,  exp_f);
      check("repeat", rep_out,   exp_rep);
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for 3 edges with both switches high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level",  level_out, 2'b00);
    check("rst_rise",   rise_out,  2'b00);
    check("rst_fall",   fall_out,  2'b00);
    check("rst_repeat", rep_out,   2'b00);
    step(1);
    rst_n = 1'b1;
    push_ev(cyc + LAT, 2'b11, 2'b00);   // switches already high -> normal rise
    step(40);
    sw = 2'b00;
    push_ev(cyc + LAT, 2'b00, 2'b11);
    step(20);

    // Clean step on ch0, held long enough for repeats, then released.
    sw = 2'b01;
    push_ev(cyc + LAT, 2'b01, 2'b00);
    step(30);
    sw = 2'b00;
    push_ev(cyc + LAT, 2'b00, 2'b01);
    step(20);

    // Bounce on ch1: 3-cycle dwell, then steady high.
    sw = 2'b10; step(3);
    sw = 2'b00; step(3);
    sw = 2'b10; step(3);
    sw = 2'b00; step(3);
    sw = 2'b10;
    push_ev(cyc + LAT, 2'b10, 2'b00);
    step(20);
    sw = 2'b00;
    push_ev(cyc + LAT, 2'b00, 2'b10);
    step(20);

    // Glitch of LIMIT-1 cycles is rejected; LIMIT cycles is accepted.
    sw = 2'b01; step(LIMIT - 1);
    sw = 2'b00; step(20);
    sw = 2'b01;
    push_ev(cyc + LAT, 2'b01, 2'b00);
    step(LIMIT);
    sw = 2'b00;
    push_ev(cyc + LAT, 2'b00, 2'b01);
    step(20);

    // Both channels on the same edge.
    sw = 2'b11;
    push_ev(cyc + LAT, 2'b11, 2'b00);
    step(15);
    sw = 2'b00;
    push_ev(cyc + LAT, 2'b00, 2'b11);
    step(20);

    // Same step, reset sampled on edge +5 aborts the count.
    sw = 2'b11;
    step(4);
    rst_n = 1'b0;
    sb.delete();
    step(2);
    rst_n = 1'b1;
    push_ev(cyc + LAT, 2'b11, 2'b00);
    step(20);
    sw = 2'b00;
    push_ev(cyc + LAT, 2'b00, 2'b11);
    step(20);

    @(negedge clk);
    check("events_left", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
